// File: rtl/expr_result_unpacker.sv
// expr_result_unpacker: receives one 90-bit packed expression result word
// (18 fields y0..y17, y0 in the MSBs) and replays the fields one per beat.
// Each field is extended to OUT_W bits. Fields 3-5, 9-11 and 15-17 are
// sign-extended. All other fields are zero-extended.
// Optional feature: define EXPR_UNPACK_CHECKSUM_EN to add chk_valid/chk_data.
// chk_data is a per-word XOR of all emitted beats.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. While valid is high and the transfer has not happened, the
// sender holds its data stable. ready may depend combinationally on the
// other side's ready: in_ready follows out_ready during the final beat, so a
// new word can be taken without a bubble.
module expr_result_unpacker #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [89:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [4:0]       out_idx,
  output logic             out_signed,
  output logic             out_last
`ifdef EXPR_UNPACK_CHECKSUM_EN
  ,
  output logic             chk_valid,
  output logic [OUT_W-1:0] chk_data
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [4:0] LAST_IDX = 5'd17;

  state_t      state, n_state;
  logic [89:0] word, n_word;
  logic [4:0]  idx, n_idx;
  logic        capture;
  logic        beat_acc;

  // Fields 3..5 of every six-field group are signed.
  function automatic logic field_signed(input logic [4:0] i);
    return (int'(i) % 6) >= 3;
  endfunction

  // Pull field i out of the packed word and extend it to OUT_W bits.
  // Within each 15-bit group of three, the field widths are 4, 5 and 6 bits.
  function automatic logic [OUT_W-1:0] field_value(input logic [89:0] w,
                                                   input logic [4:0]  i);
    int grp;
    int sub;
    int width;
    int off;
    logic [6:0] lsb;
    logic       fill;
    logic [OUT_W-1:0] r;
    grp   = int'(i) / 3;
    sub   = int'(i) % 3;
    width = 4 + sub;
    case (sub)
      0:       off = 0;
      1:       off = 4;
      default: off = 9;
    endcase
    lsb  = 7'(89 - 15 * grp - off - width + 1);
    fill = field_signed(i) & w[lsb + 7'(width - 1)];
    r    = '0;
    for (int b = 0; b < OUT_W; b++) begin
      r[b] = (b < width) ? w[lsb + 7'(b)] : fill;
    end
    return r;
  endfunction

  // Ready when idle, or when the final beat is leaving this cycle.
  always_comb begin
    in_ready = (state == IDLE) ||
               ((state == EMIT) && (idx == LAST_IDX) && out_ready);
  end

  assign capture  = in_valid && in_ready;
  assign beat_acc = (state == EMIT) && out_ready;
  assign out_idx  = idx;

  // Next word / index / state, shared by the state register and the
  // registered output computation.
  always_comb begin
    n_state = state;
    n_word  = word;
    n_idx   = idx;
    if (capture) begin
      n_state = EMIT;
      n_word  = in_data;
      n_idx   = 5'd0;
    end else if (beat_acc) begin
      if (idx == LAST_IDX) begin
        n_state = IDLE;
        n_idx   = 5'd0;
      end else begin
        n_idx = idx + 5'd1;
      end
    end
  end

  // State, held word and registered beat outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      idx        <= 5'd0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_signed <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      state     <= n_state;
      word      <= n_word;
      idx       <= n_idx;
      out_valid <= (n_state == EMIT);
      if (n_state == EMIT) begin
        out_data   <= field_value(n_word, n_idx);
        out_signed <= field_signed(n_idx);
        out_last   <= (n_idx == LAST_IDX);
      end else begin
        out_data   <= '0;
        out_signed <= 1'b0;
        out_last   <= 1'b0;
      end
    end
  end

`ifdef EXPR_UNPACK_CHECKSUM_EN
  logic [OUT_W-1:0] acc;

  // Running XOR of accepted beats. It pulses chk_valid after the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      chk_valid <= 1'b0;
      chk_data  <= '0;
    end else begin
      chk_valid <= 1'b0;
      if (capture) begin
        acc <= '0;
      end else if (beat_acc) begin
        acc <= acc ^ out_data;
      end
      if (beat_acc && (idx == LAST_IDX)) begin
        chk_valid <= 1'b1;
        chk_data  <= acc ^ out_data;
      end
    end
  end
`endif

endmodule

// File: doc/expr_result_unpacker.md
Name: expr_result_unpacker

Overview:
- Receiving end of the 90-bit packed expression result bus (18 fields y0..y17, y0 in the MSBs).
- Accepts one packed word per valid/ready handshake, then emits the 18 fields one per beat on a streaming output.
- Each field is extended to OUT_W bits: signed fields are sign-extended, unsigned fields are zero-extended.
- Sits between the expression-under-test and the result checker / scoreboard logic.

Parameters:
- OUT_W, 8, output field width. Must be >= 6. Field widths are fixed by the bus layout.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  packed word present.
- in_ready  output  1  unpacker can accept a word this cycle.
- in_data  input  90  packed word; y0 at [89:86].
- out_valid  output  1  field beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  OUT_W  extended field value.
- out_idx  output  5  field index, 0..17.
- out_signed  output  1  current field is signed.
- out_last  output  1  beat is field 17.

Behaviour:
- Field layout:
  - Width of field i by i%3: 0 -> 4 bits, 1 -> 5 bits, 2 -> 6 bits.
  - Field i is signed when (i%6) >= 3.
  - MSB of field i = 89 - 15*(i/3) - {0,4,9}[i%3]. Examples: y0 [89:86], y1 [85:81], y2 [80:75], y3 [74:71], y17 [5:0].
- Reset values: out_valid=0, out_data=0, out_idx=0, out_signed=0, out_last=0, held word=0, state IDLE. in_ready=1 from the first cycle after reset.
- State machine with two states, IDLE and EMIT.
  - IDLE: in_ready=1, out_valid=0, out_data=0. When in_valid=1, capture in_data, set idx=0, go to EMIT. The first beat is valid the cycle after capture (1-cycle latency).
  - EMIT: out_valid=1. out_data, out_signed and out_last are derived from the held word and idx.
    - out_valid & out_ready with idx<17: idx increments.
    - out_valid & out_ready with idx==17: the word completes.
  - On completion:
    - in_valid=1 in the same cycle: capture the new word, idx=0, stay in EMIT (zero bubble).
    - Otherwise: go to IDLE.
- in_ready = (state==IDLE) | (state==EMIT & idx==17 & out_ready). This is the only combinational in-to-out path. Everything else is registered.
- Backpressure: while out_ready=0, out_data, out_idx, out_last and the held word stay stable. in_data is ignored.
- Throughput: 18 cycles per word with out_ready held high.
- out_last=1 only when idx==17 and out_valid=1.
- Synchronous reset mid-word: the current word is dropped. Next cycle out_valid=0, idx=0, state IDLE. No partial completion is signalled.
- in_valid asserted with in_ready=0: no capture. The upstream must hold the word until it is accepted.

Optional Feature:
- Macro: EXPR_UNPACK_CHECKSUM_EN.
- Defined:
  - Adds output ports chk_valid (1) and chk_data (OUT_W).
  - A running XOR of every accepted out_data beat of the current word is kept. It clears when a new word is captured.
  - chk_valid pulses high for exactly one cycle, the cycle after the idx==17 beat is accepted. chk_data holds the final XOR and stays until the next pulse.
  - Reset: chk_valid=0, chk_data=0. A word aborted by reset produces no pulse.
- Undefined: the ports and logic are absent. Everything else is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> out_valid=0, out_data=0, out_idx=0, in_ready=1.
- Extension: in_data with [89:86]=4'hF and [74:71]=4'h8, rest 0 ->
  - idx0: out_data=8'h0F, out_signed=0.
  - idx3: out_data=8'hF8, out_signed=1.
  - All other beats 8'h00.
- All-ones word:
  - Beats repeat 0x0F,0x1F,0x3F,0xFF,0xFF,0xFF three times.
  - out_last=1 only on idx17.
  - With the macro defined: chk_data=8'hD0, chk_valid pulses once.
- Backpressure: out_ready=0 for 5 cycles at idx7 -> idx, out_data and out_valid stay stable, in_ready=0. Beat 7 is accepted on the cycle out_ready returns.
- Back-to-back: second word presented with in_valid=1 during idx17 with out_ready=1 -> captured that cycle, idx0 of the second word in the next cycle. 36 beats arrive in 36 consecutive cycles.
- Reset mid-word: rst=1 at idx9 -> next cycle out_valid=0, idx=0, in_ready=1. No out_last and no chk_valid for the aborted word.
